alu_cmd_sequencer: RTL

- Control stage wrapped around the 8-bit combinational ALU (controls zx,nx,zy,ny,f,no; flags zr,ng).
- Accepts commands over a valid/ready handshake and reads operands from a small register file.
- Drives the ALU for one registered cycle, then captures o/zr/ng and optionally writes o back.
- Returns the result over a second valid/ready handshake. Feeds the ALU and consumes its outputs.

---
 rtl/alu_cmd_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer wrapped around an external combinational ALU.
// Optional flag-consistency checker enabled by defining ALU_FLAG_CHECK_EN.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int RAW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [5:0]       cmd_ctrl,
  input  logic [RAW-1:0]   cmd_src_a,
  input  logic [RAW-1:0]   cmd_src_b,
  input  logic             cmd_imm_en,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic             cmd_wr,
  input  logic [RAW-1:0]   cmd_dst,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zr,
  output logic             rsp_ng,
  output logic             flag_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];
  logic [WIDTH-1:0] alu_x_q, alu_x_d;
  logic [WIDTH-1:0] alu_y_q, alu_y_d;
  logic [5:0]       alu_ctrl_q, alu_ctrl_d;
  logic             wr_q, wr_d;
  logic [RAW-1:0]   dst_q, dst_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zr_q, rsp_zr_d;
  logic             rsp_ng_q, rsp_ng_d;
  logic             accept;
  logic             exec;

  assign cmd_ready = (state_q == IDLE) |
                     ((state_q == RESP) & rsp_ready);
  assign accept    = cmd_valid & cmd_ready;
  assign exec      = (state_q == EXEC);

  always_comb begin
    state_d    = state_q;
    rf_d       = rf_q;
    alu_x_d    = alu_x_q;
    alu_y_d    = alu_y_q;
    alu_ctrl_d = alu_ctrl_q;
    wr_d       = wr_q;
    dst_d      = dst_q;
    rsp_data_d = rsp_data_q;
    rsp_zr_d   = rsp_zr_q;
    rsp_ng_d   = rsp_ng_q;

    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Operands are sampled before this cycle's write-back lands.
    if (accept) begin
      alu_x_d    = rf_q[cmd_src_a];
      alu_y_d    = cmd_imm_en ? cmd_imm : rf_q[cmd_src_b];
      alu_ctrl_d = cmd_ctrl;
      wr_d       = cmd_wr;
      dst_d      = cmd_dst;
    end

    if (exec) begin
      rsp_data_d = alu_o;
      rsp_zr_d   = alu_zr;
      rsp_ng_d   = alu_ng;
      if (wr_q) rf_d[dst_q] = alu_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      alu_ctrl_q <= '0;
      wr_q       <= 1'b0;
      dst_q      <= '0;
      rsp_data_q <= '0;
      rsp_zr_q   <= 1'b0;
      rsp_ng_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      alu_x_q    <= alu_x_d;
      alu_y_q    <= alu_y_d;
      alu_ctrl_q <= alu_ctrl_d;
      wr_q       <= wr_d;
      dst_q      <= dst_d;
      rsp_data_q <= rsp_data_d;
      rsp_zr_q   <= rsp_zr_d;
      rsp_ng_q   <= rsp_ng_d;
    end
  end

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_ng    = rsp_ng_q;

`ifdef ALU_FLAG_CHECK_EN
  logic flag_err_q, flag_err_d;
  logic flag_bad;

  assign flag_bad = (alu_zr != (alu_o == '0)) |
                    (alu_ng != alu_o[WIDTH-1]);

  // Sticky until reset.
  always_comb begin
    flag_err_d = flag_err_q;
    if (exec & flag_bad) flag_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_err_q <= 1'b0;
    else        flag_err_q <= flag_err_d;
  end

  assign flag_err = flag_err_q;
`else
  assign flag_err = 1'b0;
`endif

endmodule
